// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package inst_prefetch_queue_pkg;

   // Default queue capacity in 32-bit instruction entries (power of two, >= 2).
   localparam int DEPTH_DEFAULT = 4;

   // Fetch control states.
   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_FETCH = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   // One queued instruction together with its byte address.
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } entry_t;

   // First byte address of the 8-byte line that follows the one holding pc.
   function automatic logic [63:0] next_line(input logic [63:0] pc);
      return {pc[63:3] + 61'd1, 3'b000};
   endfunction

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Bus and decode-side signal bundle of the prefetch queue.
// The master side is the queue itself; the slave side is the memory bus
// plus the decode stage.
interface inst_prefetch_queue_if;
   logic [63:0] HADDR;
   logic        HTRANS;
   logic [63:0] HRDATA;
   logic        stall;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;

   modport master (
      output HADDR, HTRANS, inst, inst_pc, inst_valid,
      input  HRDATA, stall, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  HADDR, HTRANS, inst, inst_pc, inst_valid,
      output HRDATA, stall, redirect, redirect_pc, inst_ready
   );
endinterface

// File: rtl/inst_prefetch_queue_fifo.sv
// Dual-push, single-pop instruction storage with pointer and count logic.
// The head entry is presented combinationally; an empty queue shows zeros.
module prefetch_fifo
   import inst_prefetch_queue_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEFAULT,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_flush,
   input  logic [1:0]       i_push_cnt,
   input  entry_t           i_push0,
   input  entry_t           i_push1,
   input  logic             i_pop,
   output entry_t           o_head,
   output logic             o_valid,
   output logic [CNT_W-1:0] o_count_next
);

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_pop;
   logic [PTR_W-1:0] w_wr_ptr_1;
   logic [CNT_W-1:0] w_count_next;

   // Qualify the pop and compute the occupancy after this edge.
   always_comb begin
      w_pop      = i_pop && (r_count != '0) && !i_flush;
      w_wr_ptr_1 = r_wr_ptr + PTR_W'(1);
      if (i_flush) begin
         w_count_next = '0;
      end else begin
         w_count_next = r_count + CNT_W'(i_push_cnt) - CNT_W'(w_pop);
      end
   end

   // Pointers, count and storage; a flush empties the queue and drops any push.
   // Pointers wrap naturally because DEPTH is a power of two, so the second
   // word of a straddling push lands in slot 0.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_count  <= w_count_next;
         r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_cnt);
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
         if (i_push_cnt != 2'd0) begin
            r_mem[r_wr_ptr] <= i_push0;
         end
         if (i_push_cnt == 2'd2) begin
            r_mem[w_wr_ptr_1] <= i_push1;
         end
      end
   end

   // Head presentation with no added latency.
   always_comb begin
      o_valid      = (r_count != '0);
      o_head       = o_valid ? r_mem[r_rd_ptr] : '0;
      o_count_next = w_count_next;
   end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches 8-byte lines from the bus, splits
// them into 32-bit instructions and queues them for the decode stage.
// The fetch FSM and fetch address live here; storage lives in prefetch_fifo.
module inst_prefetch_queue
   import inst_prefetch_queue_pkg::*;
#(
   parameter  int          DEPTH    = DEPTH_DEFAULT,
   parameter  logic [63:0] RESET_PC = 64'h0,
   localparam int          CNT_W    = $clog2(DEPTH) + 1
) (
   input logic                    CLK,
   input logic                    RESET,
   inst_prefetch_queue_if.master  bus
);

   state_t           r_state;
   state_t           w_state_next;
   logic [63:0]      r_fetch_pc;
   logic [63:0]      w_fetch_pc_next;

   logic             w_htrans;
   logic             w_accept;
   logic             w_pop;
   logic [1:0]       w_push_cnt;
   entry_t           w_push0;
   entry_t           w_push1;
   entry_t           w_head;
   logic             w_head_valid;
   logic [CNT_W-1:0] w_count_next;
   logic [CNT_W-1:0] w_free;
   logic [CNT_W-1:0] w_need;
   logic             w_room_ok;
   logic             w_unused_ok;

   // The two low redirect target bits are intentionally ignored.
   assign w_unused_ok = &{1'b0, bus.redirect_pc[1:0]};

   // Request/accept decode and split of the captured line into queue entries.
   // An odd-word fetch address only keeps the upper word of the line.
   always_comb begin
      w_htrans   = (r_state == S_FETCH) && !bus.redirect;
      w_accept   = w_htrans && !bus.stall;
      w_pop      = bus.inst_ready && !bus.redirect;
      w_push_cnt = 2'd0;
      w_push0    = '0;
      w_push1    = '0;
      if (w_accept) begin
         if (r_fetch_pc[2]) begin
            w_push_cnt   = 2'd1;
            w_push0.pc   = r_fetch_pc;
            w_push0.inst = bus.HRDATA[63:32];
         end else begin
            w_push_cnt   = 2'd2;
            w_push0.pc   = r_fetch_pc;
            w_push0.inst = bus.HRDATA[31:0];
            w_push1.pc   = r_fetch_pc + 64'd4;
            w_push1.inst = bus.HRDATA[63:32];
         end
      end
   end

   // Next fetch address and FSM transitions; redirect overrides everything.
   // Room is judged against the occupancy after this edge and the size of
   // the transfer that the next fetch address will produce.
   always_comb begin
      w_state_next    = r_state;
      w_fetch_pc_next = r_fetch_pc;
      if (w_accept) begin
         w_fetch_pc_next = next_line(r_fetch_pc);
      end
      w_free    = CNT_W'(DEPTH) - w_count_next;
      w_need    = w_fetch_pc_next[2] ? CNT_W'(1) : CNT_W'(2);
      w_room_ok = (w_free >= w_need);
      case (r_state)
         S_START: w_state_next = S_FETCH;
         S_FETCH: if (!w_room_ok) w_state_next = S_FULL;
         S_FULL:  if (w_room_ok)  w_state_next = S_FETCH;
         default: w_state_next = S_START;
      endcase
      if (bus.redirect) begin
         w_state_next    = S_FETCH;
         w_fetch_pc_next = {bus.redirect_pc[63:2], 2'b00};
      end
   end

   // State and fetch address registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= S_START;
         r_fetch_pc <= {RESET_PC[63:2], 2'b00};
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
      end
   end

   prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK          (CLK),
      .RESET        (RESET),
      .i_flush      (bus.redirect),
      .i_push_cnt   (w_push_cnt),
      .i_push0      (w_push0),
      .i_push1      (w_push1),
      .i_pop        (w_pop),
      .o_head       (w_head),
      .o_valid      (w_head_valid),
      .o_count_next (w_count_next)
   );

   assign bus.HTRANS     = w_htrans;
   assign bus.HADDR      = {r_fetch_pc[63:3], 3'b000};
   assign bus.inst       = w_head.inst;
   assign bus.inst_pc    = w_head.pc;
   assign bus.inst_valid = w_head_valid;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a scoreboard-driven pop monitor.
module tb_inst_prefetch_queue;
   import inst_prefetch_queue_pkg::*;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;
   always #5 CLK = ~CLK;

   inst_prefetch_queue_if bus ();

   inst_prefetch_queue #(
      .DEPTH    (4),
      .RESET_PC (64'h0)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   entry_t exp_q[$];
   entry_t mon_e;
   int     n_checks = 0;
   int     n_pass   = 0;
   int     n_pops   = 0;

   // Memory image: two hand-written lines at 0x0 and 0x8, elsewhere the
   // word at byte address p reads as 0xF000_0000 | p.
   function automatic logic [63:0] mem_data(input logic [63:0] a);
      if (a == 64'h0) return 64'hBBBB_BBBB_AAAA_AAAA;
      if (a == 64'h8) return 64'hDDDD_DDDD_CCCC_CCCC;
      return {32'hF000_0000 | (a[31:0] + 32'd4), 32'hF000_0000 | a[31:0]};
   endfunction

   always_comb bus.HRDATA = mem_data(bus.HADDR);

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic push_exp(input logic [63:0] pc, input logic [31:0] ins);
      entry_t e;
      e.pc   = pc;
      e.inst = ins;
      exp_q.push_back(e);
   endtask

   // Monitor: every pop the DUT is about to perform is checked against the scoreboard.
   always @(negedge CLK) begin
      if (RESET && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: got pc %h, expected no entry", bus.inst_pc);
         end else begin
            mon_e = exp_q.pop_front();
            $display("pop pc=%h inst=%h (expected pc=%h inst=%h)", bus.inst_pc, bus.inst, mon_e.pc, mon_e.inst);
            check("sb_pc", bus.inst_pc, mon_e.pc);
            check("sb_inst", 64'(bus.inst), 64'(mon_e.inst));
            n_pops++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int target;
      int cyc;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 64'h0;
      bus.inst_ready  = 1'b0;

      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_htrans", 64'(bus.HTRANS), 64'd0);
      check("rst_valid", 64'(bus.inst_valid), 64'd0);
      check("rst_inst", 64'(bus.inst), 64'd0);
      check("rst_inst_pc", bus.inst_pc, 64'd0);
      check("rst_haddr", bus.HADDR, 64'd0);

      // Fill from reset: two lines, four entries, then full
      push_exp(64'h0, 32'hAAAA_AAAA);
      push_exp(64'h4, 32'hBBBB_BBBB);
      push_exp(64'h8, 32'hCCCC_CCCC);
      push_exp(64'hC, 32'hDDDD_DDDD);
      @(posedge CLK); #1 RESET = 1'b1;
      @(negedge CLK);
      check("start_htrans", 64'(bus.HTRANS), 64'd0);
      @(negedge CLK);
      check("fetch0_htrans", 64'(bus.HTRANS), 64'd1);
      check("fetch0_haddr", bus.HADDR, 64'h0);
      check("fetch0_valid", 64'(bus.inst_valid), 64'd0);
      @(negedge CLK);
      check("fetch8_valid", 64'(bus.inst_valid), 64'd1);
      check("fetch8_haddr", bus.HADDR, 64'h8);
      check("fetch8_htrans", 64'(bus.HTRANS), 64'd1);
      @(negedge CLK);
      check("full_htrans", 64'(bus.HTRANS), 64'd0);
      @(negedge CLK);
      check("full_htrans2", 64'(bus.HTRANS), 64'd0);
      check("full_head_pc", bus.inst_pc, 64'h0);
      check("full_head_inst", 64'(bus.inst), 64'hAAAA_AAAA);

      // One pop: still no room for a line
      @(posedge CLK); #1 bus.inst_ready = 1'b1;
      @(posedge CLK); #1 bus.inst_ready = 1'b0;
      @(negedge CLK);
      check("pop1_htrans", 64'(bus.HTRANS), 64'd0);
      check("pop1_head_pc", bus.inst_pc, 64'h4);

      // Second pop frees two slots: request 0x10, held under stall
      @(posedge CLK); #1 bus.inst_ready = 1'b1;
      @(posedge CLK); #1 begin bus.inst_ready = 1'b0; bus.stall = 1'b1; end
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("stall_htrans", 64'(bus.HTRANS), 64'd1);
         check("stall_haddr", bus.HADDR, 64'h10);
         check("stall_head_pc", bus.inst_pc, 64'h8);
         @(posedge CLK);
      end
      #1 bus.stall = 1'b0;
      @(negedge CLK);
      check("unstall_haddr", bus.HADDR, 64'h10);
      @(negedge CLK);
      check("refull_htrans", 64'(bus.HTRANS), 64'd0);
      check("refull_haddr", bus.HADDR, 64'h18);
      check("refull_head_pc", bus.inst_pc, 64'h8);

      // Redirect to 0x104 while full
      @(posedge CLK); #1 begin bus.redirect = 1'b1; bus.redirect_pc = 64'h104; exp_q.delete(); end
      @(negedge CLK);
      check("redir_htrans", 64'(bus.HTRANS), 64'd0);
      @(posedge CLK); #1 bus.redirect = 1'b0;
      @(negedge CLK);
      check("redir_valid", 64'(bus.inst_valid), 64'd0);
      check("redir_haddr", bus.HADDR, 64'h100);
      check("redir_htrans1", 64'(bus.HTRANS), 64'd1);
      @(negedge CLK);
      check("redir_valid1", 64'(bus.inst_valid), 64'd1);
      check("redir_head_pc", bus.inst_pc, 64'h104);
      check("redir_head_inst", 64'(bus.inst), 64'hF000_0104);
      check("redir_haddr2", bus.HADDR, 64'h108);

      // Streaming: 40 consecutive instructions from 0x104 (ten pointer wraps)
      for (int k = 0; k < 40; k++) begin
         push_exp(64'h104 + 64'(4 * k), 32'hF000_0104 + 32'(4 * k));
      end
      target = n_pops + 40;
      @(posedge CLK); #1 bus.inst_ready = 1'b1;
      cyc = 0;
      while (n_pops < target && cyc < 400) begin
         @(posedge CLK); #1;
         cyc++;
      end
      bus.inst_ready = 1'b0;
      if (cyc >= 400) begin
         n_checks++;
         $display("FAIL stream_timeout: got %0d pops, expected %0d", n_pops, target);
      end
      check("stream_drained", 64'(exp_q.size()), 64'd0);

      // Redirect with low bits set, then reset mid-transfer
      @(posedge CLK); #1 begin bus.redirect = 1'b1; bus.redirect_pc = 64'h303; exp_q.delete(); end
      @(posedge CLK); #1 bus.redirect = 1'b0;
      @(negedge CLK);
      check("mask_haddr", bus.HADDR, 64'h300);
      check("mask_htrans", 64'(bus.HTRANS), 64'd1);
      @(negedge CLK);
      check("pre_rst_htrans", 64'(bus.HTRANS), 64'd1);
      check("pre_rst_head_pc", bus.inst_pc, 64'h300);
      #1 RESET = 1'b0;
      #1;
      check("async_rst_htrans", 64'(bus.HTRANS), 64'd0);
      check("async_rst_valid", 64'(bus.inst_valid), 64'd0);
      check("async_rst_inst_pc", bus.inst_pc, 64'd0);
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b1;
      @(negedge CLK);
      check("rel_start_htrans", 64'(bus.HTRANS), 64'd0);
      @(negedge CLK);
      check("rel_htrans", 64'(bus.HTRANS), 64'd1);
      check("rel_haddr", bus.HADDR, 64'h0);
      check("rel_valid", 64'(bus.inst_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue capacity in 32-bit instruction entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 64'h0, SHALL set the fetch address after reset.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  SHALL be asynchronous and active-low; low clears all state immediately.
REQ-005 HRDATA  input  64  SHALL be the read data of the current granted bus transfer, valid in the same cycle.
REQ-006 stall  input  1  SHALL mean the bus is not granted this cycle; the transfer is not accepted.
REQ-007 HADDR  output  64  SHALL carry the 8-byte-aligned fetch address.
REQ-008 HTRANS  output  1  SHALL be the fetch request.
REQ-009 redirect  input  1  SHALL mean a control-flow change request.
REQ-010 redirect_pc  input  64  SHALL be the new fetch target; bits [1:0] ignored.
REQ-011 inst  output  32  SHALL be the instruction at queue head.
REQ-012 inst_pc  output  64  SHALL be the byte address of inst.
REQ-013 inst_valid  output  1  SHALL mean inst/inst_pc hold a valid entry.
REQ-014 inst_ready  input  1  SHALL mean the decode stage consumes the head this cycle.

Function
REQ-015 A transfer SHALL be accepted on a rising edge where HTRANS=1 and stall=0; HRDATA SHALL be captured at that edge.
REQ-016 HADDR SHALL equal {fetch_pc[63:3],3'b000}.
REQ-017 If fetch_pc[2]=0, an accepted transfer SHALL push HRDATA[31:0] (pc=fetch_pc) then HRDATA[63:32] (pc=fetch_pc+4), and fetch_pc SHALL advance by 8.
REQ-018 If fetch_pc[2]=1, only HRDATA[63:32] SHALL be pushed, and fetch_pc SHALL advance to the next 8-byte boundary.
REQ-019 FSM states: S_START, S_FETCH, S_FULL; HTRANS=1 only in S_FETCH with redirect=0.
REQ-020 S_START SHALL hold for exactly one cycle after RESET deasserts, then enter S_FETCH.
REQ-021 S_FETCH to S_FULL when free entries after this cycle's push/pop are fewer than needed by the next transfer (2, or 1 if fetch_pc[2]=1); S_FULL to S_FETCH when that room exists.
REQ-022 A pop SHALL occur on a rising edge with inst_valid=1 and inst_ready=1; inst_ready with inst_valid=0 SHALL have no effect.
REQ-023 Push and pop in the same cycle SHALL both take effect; count_next = count + pushes - pop; count SHALL never exceed DEPTH or go below 0.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; a two-entry push straddling the wrap SHALL land in the last and first slots.
REQ-025 inst_valid SHALL equal (count != 0); inst/inst_pc SHALL be driven from the head entry with no added latency.
REQ-026 redirect SHALL take priority over push and pop: at that edge the queue SHALL be emptied, any accepted data discarded, fetch_pc loaded with {redirect_pc[63:2],2'b00}, state set to S_FETCH.
REQ-027 Minimum latency: redirect at edge N, first request edge N+1, inst_valid=1 after edge N+1 if stall=0.
REQ-028 stall held high SHALL keep HTRANS and HADDR stable; no push.

Reset
REQ-029 With RESET low: fetch_pc=RESET_PC, count=0, pointers=0, state=S_START, HTRANS=0, inst_valid=0, inst=0, inst_pc=0.
REQ-030 RESET asserted mid-transfer SHALL drop HTRANS in the same cycle and discard all queued entries.

Structure
REQ-031 A shared package SHALL hold the FSM state typedef, the entry struct {pc[63:0], inst[31:0]} and the DEPTH default.
REQ-032 Storage and pointer/count logic SHALL live in one sub-module, prefetch_fifo (dual-push, single-pop); the FSM and fetch_pc stay in inst_prefetch_queue.

Verification
REQ-033 Reset release, stall=0, inst_ready=0, HRDATA=64'hBBBB_BBBB_AAAA_AAAA at 0x0, 64'hDDDD_DDDD_CCCC_CCCC at 0x8: queue holds AAAA_AAAA@0, BBBB_BBBB@4, CCCC_CCCC@8, DDDD_DDDD@C; then HTRANS=0, state S_FULL.
REQ-034 Full queue, inst_ready=1 for one cycle: one pop, count 3, no request; second pop: count 2, HTRANS=1 next cycle, HADDR=0x10.
REQ-035 redirect with redirect_pc=0x104 while full: next cycle inst_valid=0, HADDR=0x100; after accept only HRDATA[63:32] pushed with pc 0x104.
REQ-036 stall=1 for 5 cycles: HTRANS=1, HADDR unchanged, count unchanged; stall drops: one accept.
REQ-037 Continuous inst_ready=1, stall=0: pointers wrap at least three times, inst_pc strictly +4 per pop, no loss or duplication.
REQ-038 RESET asserted while HTRANS=1 and count=3: HTRANS=0 and inst_valid=0 immediately; after release one S_START cycle, then HADDR=RESET_PC.
